// File: rtl/vrb_pkg.sv
// rtl/vrb_pkg.sv - shared FSM state, lane-count and counter-width definitions for vrb_dram
package vrb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DW_DEFAULT = 32;
    localparam int LANES      = DW_DEFAULT / 8;
    localparam int CNT_W      = 4;

    function automatic int lanes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/vrb_dram_array.sv
// rtl/vrb_dram_array.sv - single-port word storage, per-byte synchronous write, registered read
module vrb_dram_array #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH),
    parameter int NB    = DW / 8
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [NB-1:0] wr_lanes,
    input  logic [IW-1:0] idx,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // No reset: storage contents must survive rst.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_lanes[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/vrb_dram.sv
// rtl/vrb_dram.sv - fixed-latency VRB memory slave; VRB_DRAM_RANGE_CHECK_EN enables address range errors
module vrb_dram
    import vrb_pkg::*;
#(
    parameter int             AW        = 32,
    parameter int             DW        = 32,
    parameter int             DEPTH     = 1024,
    parameter logic [AW-1:0]  BASE_ADDR = 32'h8000_0000,
    parameter int             LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vrb_cmd_valid,
    input  logic [AW-1:0]     i_vrb_cmd_addr,
    input  logic              i_vrb_cmd_read,
    input  logic [DW-1:0]     i_vrb_cmd_wdata,
    input  logic [DW/8-1:0]   i_vrb_cmd_wmask,
    output logic              o_vrb_rsp_valid,
    output logic              o_vrb_rsp_err,
    output logic [DW-1:0]     o_vrb_rsp_rdata
);

    localparam int IW = $clog2(DEPTH);
    localparam int NB = lanes(DW);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              cmd_err;
    logic [IW-1:0]     idx;
    logic [NB-1:0]     wr_lanes;
    logic              rd_en;
    logic              read_q, err_q, err_hold;
    logic [DW-1:0]     arr_rdata, rdata_hold;

    assign accept = (state == IDLE) && i_vrb_cmd_valid && !rst;
    assign idx    = IW'((i_vrb_cmd_addr - BASE_ADDR) >> 2);

`ifdef VRB_DRAM_RANGE_CHECK_EN
    assign cmd_err = (i_vrb_cmd_addr < BASE_ADDR) ||
                     (((i_vrb_cmd_addr - BASE_ADDR) >> (IW + 2)) != '0);
`else
    assign cmd_err = 1'b0;
`endif

    assign wr_lanes = (accept && !i_vrb_cmd_read && !cmd_err) ? i_vrb_cmd_wmask : '0;
    assign rd_en    = accept && i_vrb_cmd_read && !cmd_err;

    vrb_dram_array #(.DW(DW), .DEPTH(DEPTH), .IW(IW), .NB(NB)) u_array (
        .clk      (clk),
        .rd_en    (rd_en),
        .wr_lanes (wr_lanes),
        .idx      (idx),
        .wdata    (i_vrb_cmd_wdata),
        .rdata    (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (i_vrb_cmd_valid) next_state = (LATENCY > 1) ? WAIT : RESP;
            WAIT: if (cnt == '0) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == IDLE && i_vrb_cmd_valid) begin
            cnt <= CNT_LOAD;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_hold <= '0;
            err_hold   <= 1'b0;
        end else begin
            if (accept) begin
                read_q <= i_vrb_cmd_read;
                err_q  <= cmd_err;
            end
            if (state == RESP) begin
                rdata_hold <= o_vrb_rsp_rdata;
                err_hold   <= o_vrb_rsp_err;
            end
        end
    end

    // Outside RESP the response fields replay the last delivered response.
    always_comb begin
        o_vrb_rsp_valid = (state == RESP);
        o_vrb_rsp_err   = err_hold;
        o_vrb_rsp_rdata = rdata_hold;
        if (state == RESP) begin
            o_vrb_rsp_err   = err_q;
            o_vrb_rsp_rdata = (read_q && !err_q) ? arr_rdata : '0;
        end
    end

endmodule

// File: tb/tb_vrb_dram.sv
// tb/tb_vrb_dram.sv - randomized self-checking bench for vrb_dram against a word-array model
module tb_vrb_dram;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 64;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_read  = 1'b0;
    logic [31:0] cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wmask = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] model [DEPTH];

    vrb_dram #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_vrb_cmd_valid (cmd_valid),
        .i_vrb_cmd_addr  (cmd_addr),
        .i_vrb_cmd_read  (cmd_read),
        .i_vrb_cmd_wdata (cmd_wdata),
        .i_vrb_cmd_wmask (cmd_wmask),
        .o_vrb_rsp_valid (rsp_valid),
        .o_vrb_rsp_err   (rsp_err),
        .o_vrb_rsp_rdata (rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic in_range(input logic [31:0] a);
`ifdef VRB_DRAM_RANGE_CHECK_EN
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < 4 * DEPTH);
`else
        return (a == a);
`endif
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off / 4) % DEPTH);
    endfunction

    task automatic xfer(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] wm, output logic [31:0] rdo, output logic erro,
                        output int n);
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rsp_valid && n < 20);
        rdo = rsp_rdata;
        erro = rsp_err;
        cmd_valid = 1'b0;
    endtask

    task automatic op(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] wm, output logic [31:0] got);
        logic [31:0] exp_d;
        logic        exp_e, e;
        int          idx, n;
        idx   = word_of(a);
        exp_e = !in_range(a);
        exp_d = (rd && !exp_e) ? model[idx] : 32'h0;
        if (!rd && !exp_e) begin
            for (int b = 0; b < 4; b++)
                if (wm[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
        end
        xfer(rd, a, wd, wm, got, e, n);
        check("latency", n, LAT);
        check("err", e, exp_e);
        check("rdata", got, exp_d);
        @(posedge clk); #1;
        check("valid_after_resp", rsp_valid, 0);
        check("rdata_hold", rsp_rdata, exp_d);
        check("err_hold", rsp_err, exp_e);
    endtask

    initial begin
        logic [31:0] got, a7, newv, a;
        int          pulses[$];
        int          extra;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_valid", rsp_valid, 0);
        check("reset_err", rsp_err, 0);
        check("reset_rdata", rsp_rdata, 0);

        for (int i = 0; i < DEPTH; i++)
            op(1'b0, BASE + 32'(4 * i), $urandom, 4'hF, got);

        op(1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, got);
        op(1'b1, 32'h8000_0010, 32'h0, 4'h0, got);
        check("sw_lw_value", got, 32'hDEAD_BEEF);

        op(1'b0, 32'h8000_0020, 32'h1122_3344, 4'hF, got);
        op(1'b0, 32'h8000_0020, 32'h0000_AB00, 4'b0010, got);
        op(1'b1, 32'h8000_0020, 32'h0, 4'h0, got);
        check("byte_mask_value", got, 32'h1122_AB44);

        op(1'b0, 32'h8000_0024, 32'h5555_AAAA, 4'h0, got);
        op(1'b1, 32'h8000_0027, 32'h0, 4'h0, got);

        for (int i = 0; i < 300; i++) begin
            a = BASE + $urandom_range(0, 8 * DEPTH - 1);
            if ($urandom_range(0, 9) == 0) a = BASE - 32'($urandom_range(1, 16));
            op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), got);
        end

        // held command: one access per LAT+1 cycles
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = BASE + 32'd20; cmd_wmask = 4'h0;
        for (int c = 1; c <= 3 * LAT + 2; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                pulses.push_back(c);
                check("held_rdata", rsp_rdata, model[5]);
            end
        end
        cmd_valid = 1'b0;
        extra = 0;
        for (int c = 0; c < 2 * (LAT + 1); c++) begin
            @(posedge clk); #1;
            if (rsp_valid) extra++;
        end
        check("held_count", pulses.size(), 3);
        check("held_pulse1", (pulses.size() > 0) ? pulses[0] : -1, LAT);
        check("held_pulse2", (pulses.size() > 1) ? pulses[1] : -1, 2 * LAT + 1);
        check("held_pulse3", (pulses.size() > 2) ? pulses[2] : -1, 3 * LAT + 2);
        check("held_extra", extra, 0);

        // reset while a write sits in WAIT
        a7 = BASE + 32'd28;
        op(1'b0, a7, 32'hCAFE_F00D, 4'hF, got);
        op(1'b1, a7, 32'h0, 4'h0, got);
        newv = $urandom | 32'h1;
        model[7] = newv;
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = a7; cmd_wdata = newv; cmd_wmask = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1; cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_valid", rsp_valid, 0);
        check("rst_mid_rdata", rsp_rdata, 0);
        check("rst_mid_err", rsp_err, 0);
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) extra++;
        end
        check("rst_no_pulse", extra, 0);
        op(1'b1, a7, 32'h0, 4'h0, got);
        check("rst_write_kept", got, newv);

`ifdef VRB_DRAM_RANGE_CHECK_EN
        op(1'b0, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, got);
        op(1'b1, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, got);
`else
        op(1'b0, BASE + 32'(4 * DEPTH), 32'h0BAD_F00D, 4'hF, got);
        op(1'b1, BASE, 32'h0, 4'h0, got);
        check("wrap_word0", got, 32'h0BAD_F00D);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vrb_dram.md
VRB_DRAM -- requirements
Module: vrb_dram

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- AW, 32, address width.
- DW, 32, data width.
- DEPTH, 1024, words of storage; power of two.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from command acceptance to response; legal range 1..15.

REQ-002 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- i_vrb_cmd_valid  in  1  command present; held by master until response.
- i_vrb_cmd_addr  in  AW  byte address.
- i_vrb_cmd_read  in  1  1 = read, 0 = write.
- i_vrb_cmd_wdata  in  DW  write data, already lane-aligned.
- i_vrb_cmd_wmask  in  DW/8  byte enables.
- o_vrb_rsp_valid  out  1  one-cycle response pulse.
- o_vrb_rsp_err  out  1  access error; qualified by o_vrb_rsp_valid.
- o_vrb_rsp_rdata  out  DW  full read word; qualified by o_vrb_rsp_valid.

Function
REQ-003 FSM states:
- IDLE -> WAIT on i_vrb_cmd_valid when LATENCY>1.
- IDLE -> RESP on i_vrb_cmd_valid when LATENCY==1.
- WAIT -> RESP when the latency counter reaches 0.
- RESP -> IDLE unconditionally.

REQ-004 A command is accepted only in IDLE with i_vrb_cmd_valid=1. read, wmask, word index and error flag are registered at the accepting edge.

REQ-005 The latency counter loads LATENCY-2 on entry to WAIT and decrements each WAIT cycle. For acceptance in cycle T, o_vrb_rsp_valid=1 exactly in cycle T+LATENCY.

REQ-006 i_vrb_cmd_valid is ignored in WAIT and RESP, because the master still holds the same command. A new command is accepted no earlier than the cycle after RESP (back-to-back accesses: one access per LATENCY+1 cycles).

REQ-007 Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits. addr[1:0] is ignored.

REQ-008 Writes are committed at the accepting edge. Each byte lane i is written only when wmask[i]=1. A write with wmask=0 changes no storage and still produces a response.

REQ-009 Reads capture the full addressed word at the accepting edge into a read register. o_vrb_rsp_rdata presents that register. For writes, o_vrb_rsp_rdata=0.

REQ-010 o_vrb_rsp_rdata and o_vrb_rsp_err hold their last value outside RESP. o_vrb_rsp_valid=0 outside RESP.

REQ-011 A read of a word written by the immediately preceding command returns the new data. No forwarding hazard exists, because accesses are serialized.

Reset
REQ-012 While rst=1 at a clock edge:
- state <- IDLE, counter <- 0.
- o_vrb_rsp_valid, o_vrb_rsp_err and o_vrb_rsp_rdata <- 0.
- Storage contents are unchanged.

REQ-013 Reset asserted in WAIT or RESP aborts the response; no o_vrb_rsp_valid pulse follows. A write accepted before the reset remains committed.

Configuration
REQ-014 With macro VRB_DRAM_RANGE_CHECK_EN defined, an address outside [BASE_ADDR, BASE_ADDR+4*DEPTH) is an error access:
- No storage write.
- rdata=0.
- o_vrb_rsp_err=1 in RESP.
- Latency is unchanged.

REQ-015 Without VRB_DRAM_RANGE_CHECK_EN:
- The address wraps modulo DEPTH words per REQ-007.
- o_vrb_rsp_err is tied to 0.

Structure
REQ-016 Shared package vrb_pkg holds:
- the FSM state enum (IDLE, WAIT, RESP);
- localparams for byte-lane count (DW/8);
- the latency-counter width (4).

REQ-017 Storage is one sub-module, vrb_dram_array: single-port, synchronous write with per-byte enable, synchronous read. vrb_dram contains only the FSM, counter, decode and response registers.

Verification
REQ-018 Write then read, LATENCY=2:
- SW to 0x8000_0010, wdata 0xDEADBEEF, wmask 0xF -> rsp_valid exactly 2 cycles after acceptance, err=0.
- LW from 0x8000_0010 -> rdata 0xDEADBEEF.

REQ-019 Byte-masked write:
- Write 0x0000_AB00 with wmask 4'b0010 over word 0x11223344 -> read returns 0x1122AB44.

REQ-020 Held command not re-accepted:
- cmd_valid kept high continuously for 3 commands, LATENCY=1 -> rsp_valid pulses on cycles 1, 3, 5 after first acceptance.
- Exactly 3 accesses occur.

REQ-021 Reset mid-operation:
- rst=1 in WAIT -> no rsp_valid pulse, outputs 0 next cycle.
- A read after reset returns the data written before reset.

REQ-022 Range check:
- With VRB_DRAM_RANGE_CHECK_EN, write to 0x7FFF_FFFC -> err=1, storage unchanged.
- Without the macro, write to 0x8000_0000+4*DEPTH -> word 0 modified, err=0.
